fft_out_reorder: RTL and testbench
==================================

// Module: fft_out_reorder
// PURPOSE
//  Output end of the 16-point FFT datapath: accepts a complete frame of 16 parallel
//  complex results from the final butterfly layer, which emits them in bit-reversed order.
//  Streams the frame out one word per handshake in natural frequency order (bin 0..15).
//  Double-buffered (ping-pong), so a new frame can be captured while the previous one drains.
// PARAMETERS
//  DW      32  word width; packed complex {re[DW-1:DW/2], im[DW/2-1:0]}, passed through untouched
//  N       16  points per frame; fixed at 16 for this datapath
//  LOGN    4   log2(N); index/counter width
//  BITREV  1   1: output bin k = input word bitrev(k); 0: output bin k = input word k
// PORTS
//  clk        in   1     clock, all state updates on rising edge
//  rst_n      in   1     asynchronous active-low reset
//  in_valid   in   1     in_frame holds a complete FFT frame
//  in_ready   out  1     a bank is free; frame captured when in_valid && in_ready
//  in_frame   in   N*DW  word j at in_frame[j*DW +: DW] (j = FFT output port index y_j)
//  out_valid  out  1     out_data/out_index/out_last are valid
//  out_ready  in   1     consumer accepts; transfer when out_valid && out_ready
//  out_data   out  DW    frequency-bin word; forced 0 when out_valid=0
//  out_index  out  LOGN  bin number of out_data (0..N-1)
//  out_last   out  1     high with bin N-1 of each frame
//  frame_cnt  out  8     completed output frames, wraps 255->0
// BEHAVIOUR
//  Storage: bank[0..1][0..N-1] of DW bits; full[0..1] flags; wr_sel, rd_sel bank pointers.
//   Storage is not reset; only the control state is reset.
//  Reset (async, rst_n=0): full=0,0; wr_sel=rd_sel=0; rd_cnt=0; frame_cnt=0.
//   Outputs during/after reset: in_ready=1, out_valid=0, out_data=0, out_index=0, out_last=0.
//  Write side
//   - in_ready = !full[wr_sel], registered-state only; no combinational path from out_ready.
//   - On capture, all N words are latched into bank[wr_sel] in that single edge,
//     full[wr_sel] is set, and wr_sel toggles.
//   - If in_valid is high while in_ready=0, the frame is not captured.
//     The producer must hold it; no drop flag is raised.
//  Read side (per-bank state: EMPTY -> FULL -> DRAINING -> EMPTY)
//   - out_valid = full[rd_sel].
//   - out_index = rd_cnt.
//   - out_data = bank[rd_sel][BITREV ? bitrev(rd_cnt) : rd_cnt].
//   - out_last = out_valid && (rd_cnt == N-1).
//   - On each transfer, rd_cnt increments.
//   - On the transfer of rd_cnt = N-1, rd_cnt wraps to 0, full[rd_sel] clears,
//     rd_sel toggles, and frame_cnt increments.
//   - Stall: while out_valid && !out_ready, all outputs hold stable.
//  Latency: a frame captured at edge T shows bin 0 on out_valid after edge T, provided the
//   read bank was empty. N transfers per frame; a continuously ready sink sees 1 word/cycle.
//  Back-to-back: if the other bank is full when the last word transfers, its bin 0 is
//   presented the very next cycle (no bubble).
//  Simultaneous: capture into bank A and the last-word transfer from bank B in the same
//   edge are both honoured. A bank cannot be written and freed in the same edge, because
//   in_ready is low while that bank is full.
//  Full: both banks full -> in_ready=0 until the last word of the read bank transfers;
//   in_ready rises on the following cycle.
//  Empty: both banks empty -> out_valid=0; out_ready is ignored.
//  Reset mid-frame: all buffered frames and the partially drained frame are discarded;
//   the next accepted frame starts again at bin 0.
// TESTING
//  1 Reset: rst_n=0 mid-cycle -> immediately in_ready=1, out_valid=0, out_data=0, frame_cnt=0.
//  2 Order: frame word j = {j,16'h0}, BITREV=1, out_ready=1 -> out_data re fields =
//    0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15; out_index=0..15; out_last only on 16th.
//  3 Stall: out_ready toggled 1,0,0,1 at bin 5 -> bin 5 data/index held 3 cycles;
//    no bin skipped or repeated.
//  4 Ping-pong full: 3 frames offered back-to-back with out_ready=0 -> frames 1,2 accepted,
//    in_ready=0 on 3rd. Release out_ready -> in_ready rises the cycle after frame 1's
//    out_last; 48 words out in order, no gap.
//  5 Streaming: continuous frames with out_ready=1 -> out_valid never drops after the first
//    word; frame_cnt reaches 8 after 128 transfers; 256 frames -> frame_cnt wraps to 0.
//  6 Reset mid-drain: rst_n=0 at bin 7 with both banks full -> out_valid=0.
//    Next frame with word j = 32'hA5A50000+j outputs bin 0 = 32'hA5A50000.

Source files
------------

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: captures a bit-reversed 16-point FFT frame in one beat and streams it out in bin order.
// Latency: bin 0 is valid the cycle after capture into an empty read bank; 1 word/cycle, no bubble between frames.
// Backpressure: in_ready drops while the write bank is full; out_ready low holds every output stable.
module fft_out_reorder #(
    parameter int DW     = 32,
    parameter int N      = 16,
    parameter int LOGN   = 4,
    parameter bit BITREV = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*DW-1:0]   in_frame,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_data,
    output logic [LOGN-1:0]   out_index,
    output logic              out_last,
    output logic [7:0]        frame_cnt
);
    logic [DW-1:0]   bank [2][N];
    logic [1:0]      full;
    logic            wr_sel;
    logic            rd_sel;
    logic [LOGN-1:0] rd_cnt;
    logic [LOGN-1:0] rd_addr;
    logic            capture;
    logic            xfer;

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
        logic [LOGN-1:0] r;
        for (int i = 0; i < LOGN; i++) begin
            r[i] = v[LOGN-1-i];
        end
        return r;
    endfunction

    // Both handshakes depend only on registered flags, so no ready-to-ready path exists.
    assign in_ready  = !full[wr_sel];
    assign capture   = in_valid && in_ready;
    assign out_valid = full[rd_sel];
    assign xfer      = out_valid && out_ready;
    assign out_index = rd_cnt;
    assign out_last  = out_valid && (rd_cnt == LOGN'(N-1));
    assign rd_addr   = BITREV ? bitrev(rd_cnt) : rd_cnt;
    assign out_data  = out_valid ? bank[rd_sel][rd_addr] : '0;

    // Frame storage carries no reset; the full flags gate all reads of it.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int j = 0; j < N; j++) begin
                bank[wr_sel][j] <= in_frame[j*DW +: DW];
            end
        end
    end

    // A bank being captured is never the bank being freed, so the two full[] updates never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full      <= '0;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            rd_cnt    <= '0;
            frame_cnt <= '0;
        end else begin
            if (capture) begin
                full[wr_sel] <= 1'b1;
                wr_sel       <= !wr_sel;
            end
            if (xfer) begin
                rd_cnt <= rd_cnt + LOGN'(1);
                if (out_last) begin
                    full[rd_sel] <= 1'b0;
                    rd_sel       <= !rd_sel;
                    frame_cnt    <= frame_cnt + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fft_out_reorder.sv
// Scoreboard bench for fft_out_reorder: captured frames are expanded into expected bin-order words,
// and a negedge monitor pops and compares on every output handshake.
module tb_fft_out_reorder;
    localparam int DW   = 32;
    localparam int N    = 16;
    localparam int LOGN = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [N*DW-1:0]   in_frame = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DW-1:0]     out_data;
    logic [LOGN-1:0]   out_index;
    logic              out_last;
    logic [7:0]        frame_cnt;

    fft_out_reorder #(.DW(DW), .N(N), .LOGN(LOGN), .BITREV(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_frame  (in_frame),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0]   data;
        logic [LOGN-1:0] idx;
        logic            last;
    } exp_t;

    exp_t            sb_q[$];
    logic [DW-1:0]   log_data[$];
    logic [LOGN-1:0] log_idx[$];
    int              log_cyc[$];
    int              checks = 0;
    int              errors = 0;
    int              cyc = 0;
    int              xfer_cnt = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Bit reversal of a 4-bit bin number, by arithmetic on the bit weights.
    function automatic int rev4(input int k);
        return ((k & 1) * 8) + ((k & 2) * 2) + ((k & 4) / 2) + ((k & 8) / 8);
    endfunction

    task automatic push_frame(input logic [N*DW-1:0] f);
        exp_t e;
        for (int k = 0; k < N; k++) begin
            e.data = f[rev4(k)*DW +: DW];
            e.idx  = LOGN'(k);
            e.last = (k == N-1);
            sb_q.push_back(e);
        end
    endtask

    // Monitor: sample away from the rising edge; a handshake seen here completes on the next edge.
    logic            stall_pend = 1'b0;
    logic [DW-1:0]   st_data;
    logic [LOGN-1:0] st_idx;
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_pend) begin
                chk("stall_hold_valid", 64'(out_valid), 64'd1);
                chk("stall_hold_data", 64'(out_data), 64'(st_data));
                chk("stall_hold_index", 64'(out_index), 64'(st_idx));
            end
            stall_pend = 1'b0;
            if (!out_valid) chk("idle_data_zero", 64'(out_data), 64'd0);
            if (in_valid && in_ready) push_frame(in_frame);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_word_index", 64'(out_index), 64'hFFFF);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("out_data", 64'(out_data), 64'(e.data));
                    chk("out_index", 64'(out_index), 64'(e.idx));
                    chk("out_last", 64'(out_last), 64'(e.last));
                end
                log_data.push_back(out_data);
                log_idx.push_back(out_index);
                log_cyc.push_back(cyc);
                xfer_cnt++;
            end else if (out_valid) begin
                stall_pend = 1'b1;
                st_data    = out_data;
                st_idx     = out_index;
            end
        end else begin
            stall_pend = 1'b0;
        end
    end

    function automatic logic [N*DW-1:0] rand_frame();
        logic [N*DW-1:0] f;
        for (int j = 0; j < N; j++) f[j*DW +: DW] = DW'($urandom);
        return f;
    endfunction

    task automatic send_frame(input logic [N*DW-1:0] f);
        bit done = 1'b0;
        in_frame = f;
        in_valid = 1'b1;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
            end
        end
        if (!done) begin
            chk("send_frame_accepted", 64'(done), 64'd1);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name);
        for (int t = 0; t < 400 && sb_q.size() != 0; t++) @(negedge clk);
        chk(name, 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic int count_gaps(input int from);
        int g = 0;
        for (int i = from + 1; i < log_cyc.size(); i++)
            if (log_cyc[i] != log_cyc[i-1] + 1) g++;
        return g;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_data"}, 64'(out_data), 64'd0);
        chk({tag, "_out_index"}, 64'(out_index), 64'd0);
        chk({tag, "_out_last"}, 64'(out_last), 64'd0);
        chk({tag, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    int              s;
    bit              found;
    logic [N*DW-1:0] f;
    int              tbl[16];

    initial begin
        tbl = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

        // Reset asserted mid-cycle must take effect immediately.
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_outputs("after_reset");

        // Natural-order readout of a ramp frame.
        out_ready = 1'b1;
        for (int j = 0; j < N; j++) f[j*DW +: DW] = {16'(j), 16'h0};
        s = log_data.size();
        send_frame(f);
        wait_drain("order_drained");
        for (int k = 0; k < N; k++) chk("order_re_field", 64'(log_data[s+k][31:16]), 64'(tbl[k]));
        chk("order_frame_cnt", 64'(frame_cnt), 64'd1);

        // Stall on bin 5 for two cycles.
        s = log_data.size();
        found = 1'b0;
        fork
            send_frame(rand_frame());
            begin
                for (int t = 0; t < 100 && !found; t++) begin
                    @(posedge clk);
                    #1;
                    if (out_valid && out_index == 4'd5) found = 1'b1;
                end
                out_ready = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        chk("stall_bin5_seen", 64'(found), 64'd1);
        wait_drain("stall_drained");
        chk("stall_bin5_span", 64'(log_cyc[s+5] - log_cyc[s+4]), 64'd3);

        // Both banks full: third frame must wait until the first frame's last word leaves.
        out_ready = 1'b0;
        s = log_data.size();
        send_frame(rand_frame());
        send_frame(rand_frame());
        found = 1'b0;
        fork
            send_frame(rand_frame());
            begin
                repeat (3) @(negedge clk);
                chk("pp_in_ready_low", 64'(in_ready), 64'd0);
                chk("pp_held_bin0", 64'(out_index), 64'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                for (int t = 0; t < 100 && !found; t++) begin
                    @(negedge clk);
                    if (out_valid && out_last) begin
                        found = 1'b1;
                        chk("pp_in_ready_at_last", 64'(in_ready), 64'd0);
                        @(negedge clk);
                        chk("pp_in_ready_after_last", 64'(in_ready), 64'd1);
                    end
                end
            end
        join
        chk("pp_last_seen", 64'(found), 64'd1);
        wait_drain("pp_drained");
        chk("pp_word_count", 64'(log_data.size() - s), 64'd48);
        chk("pp_gaps", 64'(count_gaps(s)), 64'd0);

        // Reset while draining with both banks full.
        out_ready = 1'b0;
        send_frame(rand_frame());
        send_frame(rand_frame());
        out_ready = 1'b1;
        found = 1'b0;
        for (int t = 0; t < 100 && !found; t++) begin
            @(posedge clk);
            #1;
            if (out_valid && out_index == 4'd7) found = 1'b1;
        end
        chk("rst_mid_bin7_seen", 64'(found), 64'd1);
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check_reset_outputs("rst_mid");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int j = 0; j < N; j++) f[j*DW +: DW] = 32'hA5A5_0000 + DW'(j);
        s = log_data.size();
        send_frame(f);
        wait_drain("rst_mid_drained");
        chk("rst_mid_bin0_data", 64'(log_data[s]), 64'hA5A5_0000);
        chk("rst_mid_bin0_index", 64'(log_idx[s]), 64'd0);
        chk("rst_mid_words", 64'(log_data.size() - s), 64'd16);

        // Continuous streaming of 256 frames.
        do_reset();
        out_ready = 1'b1;
        s = log_data.size();
        fork
            for (int fr = 0; fr < 256; fr++) send_frame(rand_frame());
            begin
                for (int t = 0; t < 2000 && xfer_cnt < s + 128; t++) @(negedge clk);
                @(posedge clk);
                #1;
                chk("stream_frame_cnt_8", 64'(frame_cnt), 64'd8);
            end
        join
        wait_drain("stream_drained");
        chk("stream_words", 64'(log_data.size() - s), 64'd4096);
        chk("stream_gaps", 64'(count_gaps(s)), 64'd0);
        chk("stream_frame_cnt_wrap", 64'(frame_cnt), 64'd0);
        chk("stream_idle_valid", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
